// File: rtl/cr_tlvp_usr_relay_pkg.sv
// Shared types for the TLVP user relay: TLV bus word, relay FSM states and counter width.
package cr_tlvp_usr_relay_pkg;

    localparam int unsigned CR_TLVP_RELAY_CNT_W = 32;
    localparam int unsigned TLVP_TYPEN_W        = 8;
    localparam int unsigned TLVP_DATA_W         = 64;

    typedef struct packed {
        logic [TLVP_TYPEN_W-1:0] typen;
        logic                    sot;
        logic                    eot;
        logic [TLVP_DATA_W-1:0]  tdata;
    } tlvp_if_bus_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } tlvp_relay_st_e;

endpackage

// File: rtl/cr_tlvp_relay_sat_cnt.sv
// Saturating statistics counter; adds 0..3 per cycle and sticks at all-ones.
module cr_tlvp_relay_sat_cnt #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH:0]   sum_c;

    assign sum_c = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc);
    assign cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc != 2'd0) begin
            cnt_q <= sum_c[CNT_WIDTH] ? '1 : sum_c[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cr_tlvp_usr_relay.sv
// Pops the TLVP terminate FIFO and forwards or drops whole TLVs by type into the user-insert FIFO.
module cr_tlvp_usr_relay
    import cr_tlvp_usr_relay_pkg::*;
#(
    parameter int unsigned N_TYPE_MASK = 32,
    parameter int unsigned CNT_WIDTH   = CR_TLVP_RELAY_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   term_empty,
    input  logic                   term_aempty,
    input  tlvp_if_bus_t           term_tlv,
    output logic                   term_rd,
    input  logic                   usr_full,
    input  logic                   usr_afull,
    output logic                   usr_wr,
    output tlvp_if_bus_t           usr_tlv,
    input  logic [N_TYPE_MASK-1:0] drop_mask,
    output logic [CNT_WIDTH-1:0]   pass_cnt,
    output logic [CNT_WIDTH-1:0]   drop_cnt,
    output logic [CNT_WIDTH-1:0]   err_cnt,
    output logic                   frm_err
);

    localparam int unsigned IDX_W = $clog2(N_TYPE_MASK);

    tlvp_relay_st_e   st;
    tlvp_relay_st_e   st_nxt;
    logic             ob_vld;
    tlvp_if_bus_t     ob_data;
    logic [IDX_W-1:0] type_idx_c;
    logic             sot_drop_c;
    logic             discard_c;
    logic             ob_can_load_c;
    logic             load_c;
    logic             fix_c;
    logic             err_c;
    logic [1:0]       pass_inc_c;
    logic [1:0]       drop_inc_c;
    logic             unused_c;

    assign unused_c      = term_aempty;
    assign type_idx_c    = IDX_W'(32'(term_tlv.typen) % N_TYPE_MASK);
    assign sot_drop_c    = drop_mask[type_idx_c];
    // Discarded words never need output space, so they pop even while the output is stalled.
    assign discard_c     = term_tlv.sot ? sot_drop_c : (st != PASS);
    assign usr_wr        = ob_vld & ~usr_full;
    assign ob_can_load_c = ~ob_vld | (usr_wr & ~usr_afull);
    assign term_rd       = rst_n & ~term_empty & (discard_c | ob_can_load_c);

    // Next state, output-register load and counter increments for the popped word.
    always_comb begin
        st_nxt     = st;
        load_c     = 1'b0;
        fix_c      = 1'b0;
        err_c      = 1'b0;
        pass_inc_c = 2'd0;
        drop_inc_c = 2'd0;
        if (term_rd) begin
            if (term_tlv.sot) begin
                if (st == PASS) begin
                    err_c      = 1'b1;
                    pass_inc_c = 2'd1;
                    fix_c      = ob_vld;
                end else if (st == DROP) begin
                    err_c      = 1'b1;
                    drop_inc_c = 2'd1;
                end
                if (sot_drop_c) begin
                    st_nxt = term_tlv.eot ? IDLE : DROP;
                    if (term_tlv.eot) drop_inc_c = drop_inc_c + 2'd1;
                end else begin
                    load_c = 1'b1;
                    st_nxt = term_tlv.eot ? IDLE : PASS;
                    if (term_tlv.eot) pass_inc_c = pass_inc_c + 2'd1;
                end
            end else begin
                unique case (st)
                    IDLE: err_c = 1'b1;
                    PASS: begin
                        load_c = 1'b1;
                        if (term_tlv.eot) begin
                            pass_inc_c = 2'd1;
                            st_nxt     = IDLE;
                        end
                    end
                    DROP: begin
                        if (term_tlv.eot) begin
                            drop_inc_c = 2'd1;
                            st_nxt     = IDLE;
                        end
                    end
                    default: st_nxt = IDLE;
                endcase
            end
        end
    end

    // A TLV cut short by a new sot is closed on the word currently presented.
    always_comb begin
        usr_tlv     = ob_data;
        usr_tlv.eot = ob_data.eot | fix_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ob_vld  <= 1'b0;
            ob_data <= '0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= err_c;
            if (load_c) begin
                ob_vld  <= 1'b1;
                ob_data <= term_tlv;
            end else begin
                if (usr_wr) ob_vld <= 1'b0;
                if (fix_c) ob_data.eot <= 1'b1;
            end
        end
    end

    cr_tlvp_relay_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_pass_cnt (
        .clk(clk), .rst_n(rst_n), .inc(pass_inc_c), .cnt(pass_cnt)
    );

    cr_tlvp_relay_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk(clk), .rst_n(rst_n), .inc(drop_inc_c), .cnt(drop_cnt)
    );

    cr_tlvp_relay_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk(clk), .rst_n(rst_n), .inc({1'b0, err_c}), .cnt(err_cnt)
    );

endmodule
